// File: rtl/pooling_pkg.sv
// Shared constants and state encoding for the pooling controller and its datapath.
package pooling_pkg;

  localparam int BOTTLENECK = 32;
  localparam int SIZE       = 2;
  localparam int STRIDE     = 2;
  localparam int DELTA_X    = 4;
  localparam int OU         = 4;
  localparam int IN_CH      = 512;
  localparam int IFM_BIT    = 8;
  localparam int MAX_WAIT   = 100;

  localparam int NUM_CYCLE   = BOTTLENECK / DELTA_X * OU * STRIDE;
  localparam int NUM_POOLING = IN_CH / NUM_CYCLE;
  localparam int AW          = $clog2(NUM_CYCLE);
  localparam int ACT_W       = NUM_POOLING * SIZE * SIZE * IFM_BIT;
  localparam int RES_W       = NUM_POOLING * IFM_BIT;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_ISSUE   = 3'd3,
    S_WAIT    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/pooling_ctrl_if.sv
// Activation-read, pooling-unit and result-write signals between controller and datapath.
interface pooling_ctrl_if ();
  import pooling_pkg::*;

  logic             act_rd_en;
  logic [AW-1:0]    act_rd_addr;
  logic [ACT_W-1:0] act_rd_data;
  logic             pool_in_valid;
  logic [ACT_W-1:0] pool_act;
  logic             pool_out_valid;
  logic [RES_W-1:0] pool_result;
  logic             res_wr_en;
  logic [AW-1:0]    res_wr_addr;
  logic [RES_W-1:0] res_wr_data;

  modport master (
    output act_rd_en, act_rd_addr, pool_in_valid, pool_act,
    output res_wr_en, res_wr_addr, res_wr_data,
    input  act_rd_data, pool_out_valid, pool_result
  );

  modport slave (
    input  act_rd_en, act_rd_addr, pool_in_valid, pool_act,
    input  res_wr_en, res_wr_addr, res_wr_data,
    output act_rd_data, pool_out_valid, pool_result
  );

endinterface

// File: rtl/pool_timeout_cnt.sv
// Counts WAIT cycles without a pooling response; expired flags the last allowed cycle.
module pool_timeout_cnt #(
  parameter int MAX_WAIT = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] r_cnt;

  // Wait-cycle counter, cleared whenever the controller is not waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // The cycle seen with count MAX_WAIT-1 is the MAX_WAIT-th silent cycle.
  assign o_expired = (r_cnt == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/pooling_ctrl.sv
// Sequences one layer pass: fetch a group, issue it to the pooling unit, write back the result.
module pooling_ctrl
  import pooling_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic           err,
  pooling_ctrl_if.master bus
);

  localparam logic [AW-1:0] LAST_G = AW'(NUM_CYCLE - 1);

  state_t           r_state, w_state_n;
  logic [AW-1:0]    r_g, w_g_n;
  logic             r_busy, w_busy_n;
  logic             r_done, w_done_n;
  logic             r_err, w_err_n;
  logic             r_act_rd_en, w_act_rd_en_n;
  logic [AW-1:0]    r_act_rd_addr, w_act_rd_addr_n;
  logic             r_pool_in_valid, w_pool_in_valid_n;
  logic [ACT_W-1:0] r_pool_act, w_pool_act_n;
  logic             r_res_wr_en, w_res_wr_en_n;
  logic [AW-1:0]    r_res_wr_addr, w_res_wr_addr_n;
  logic [RES_W-1:0] r_res_wr_data, w_res_wr_data_n;
  logic             w_tmr_clr, w_tmr_en, w_tmr_expired;
  logic             w_spurious;

  pool_timeout_cnt #(.MAX_WAIT(MAX_WAIT)) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_tmr_clr),
    .i_enable  (w_tmr_en),
    .o_expired (w_tmr_expired)
  );

  // A response is only legal while waiting with no write yet pending.
  assign w_spurious = bus.pool_out_valid && !((r_state == S_WAIT) && !r_res_wr_en);

  // Next state and next value of every registered output.
  always_comb begin
    w_state_n       = r_state;
    w_g_n           = r_g;
    w_err_n         = r_err;
    w_pool_act_n    = r_pool_act;
    w_res_wr_en_n   = 1'b0;
    w_res_wr_addr_n = r_res_wr_addr;
    w_res_wr_data_n = r_res_wr_data;
    w_tmr_clr       = 1'b1;
    w_tmr_en        = 1'b0;
    if (abort) begin
      w_state_n = S_IDLE;
    end else begin
      if (w_spurious) begin
        w_err_n = 1'b1;
      end else begin
        w_err_n = r_err;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_n = S_FETCH;
            w_g_n     = '0;
            w_err_n   = w_spurious;
          end else begin
            w_state_n = S_IDLE;
          end
        end
        S_FETCH:   w_state_n = S_CAPTURE;
        S_CAPTURE: begin
          w_pool_act_n = bus.act_rd_data;
          w_state_n    = S_ISSUE;
        end
        S_ISSUE:   w_state_n = S_WAIT;
        S_WAIT: begin
          w_tmr_clr = 1'b0;
          // r_res_wr_en high marks the write-back cycle of the current group.
          if (r_res_wr_en) begin
            if (r_g == LAST_G) begin
              w_state_n = S_DONE;
            end else begin
              w_g_n     = r_g + AW'(1);
              w_state_n = S_FETCH;
            end
          end else if (bus.pool_out_valid) begin
            w_res_wr_en_n   = 1'b1;
            w_res_wr_addr_n = r_g;
            w_res_wr_data_n = bus.pool_result;
          end else if (w_tmr_expired) begin
            w_err_n   = 1'b1;
            w_state_n = S_IDLE;
          end else begin
            w_tmr_en = 1'b1;
          end
        end
        S_DONE:  w_state_n = S_IDLE;
        default: w_state_n = S_IDLE;
      endcase
    end
    w_busy_n          = (w_state_n != S_IDLE);
    w_done_n          = (w_state_n == S_DONE);
    w_act_rd_en_n     = (w_state_n == S_FETCH);
    w_pool_in_valid_n = (w_state_n == S_ISSUE);
    if (w_state_n == S_FETCH) begin
      w_act_rd_addr_n = w_g_n;
    end else begin
      w_act_rd_addr_n = r_act_rd_addr;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_g             <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
      r_act_rd_en     <= 1'b0;
      r_act_rd_addr   <= '0;
      r_pool_in_valid <= 1'b0;
      r_pool_act      <= '0;
      r_res_wr_en     <= 1'b0;
      r_res_wr_addr   <= '0;
      r_res_wr_data   <= '0;
    end else begin
      r_state         <= w_state_n;
      r_g             <= w_g_n;
      r_busy          <= w_busy_n;
      r_done          <= w_done_n;
      r_err           <= w_err_n;
      r_act_rd_en     <= w_act_rd_en_n;
      r_act_rd_addr   <= w_act_rd_addr_n;
      r_pool_in_valid <= w_pool_in_valid_n;
      r_pool_act      <= w_pool_act_n;
      r_res_wr_en     <= w_res_wr_en_n;
      r_res_wr_addr   <= w_res_wr_addr_n;
      r_res_wr_data   <= w_res_wr_data_n;
    end
  end

  assign busy              = r_busy;
  assign done              = r_done;
  assign err               = r_err;
  assign bus.act_rd_en     = r_act_rd_en;
  assign bus.act_rd_addr   = r_act_rd_addr;
  assign bus.pool_in_valid = r_pool_in_valid;
  assign bus.pool_act      = r_pool_act;
  assign bus.res_wr_en     = r_res_wr_en;
  assign bus.res_wr_addr   = r_res_wr_addr;
  assign bus.res_wr_data   = r_res_wr_data;

endmodule
